assoc_wb_cache_controller: RTL and testbench

//  Parametrised set-associative, write-back, write-allocate data cache controller between the pipeline
//  MEM stage and the word-wide data memory. Multi-word lines are filled and evicted as bursts of word

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_way_array.sv | 57 +++++
 rtl/assoc_wb_cache_controller.sv | 278 +++++++++++++++++++++++++++
 tb/tb_assoc_wb_cache_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StRespond} state_t;

  localparam int unsigned MaxAddrW = 64;

  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned word_off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned data_w,
                                        input int unsigned index_bits, input int unsigned words);
    return addr_w - index_bits - word_off_w(words) - byte_off_w(data_w);
  endfunction

  // Clears the word and byte offset bits of an address.
  function automatic logic [MaxAddrW-1:0] line_base(input logic [MaxAddrW-1:0] addr,
                                                    input int unsigned low_bits);
    return (addr >> low_bits) << low_bits;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set tag, valid and dirty bits plus the line data words.
module cache_way_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned WORD_W = 2,
  parameter int unsigned TAG_W  = 23
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_data_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_fill,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_set_dirty,
  input  logic              i_clr_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned Sets  = 1 << IDX_W;
  localparam int unsigned Words = 1 << WORD_W;

  logic [Sets-1:0]         r_valid;
  logic [Sets-1:0]         r_dirty;
  logic [TAG_W-1:0]        r_tag  [Sets];
  logic [DATA_W-1:0]       r_data [Sets*Words];
  logic [IDX_W+WORD_W-1:0] w_addr;

  assign w_addr = {i_index, i_word};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill) r_valid[i_index] <= 1'b1;
      if (i_fill || i_clr_dirty) r_dirty[i_index] <= 1'b0;
      else if (i_set_dirty)      r_dirty[i_index] <= 1'b1;
    end
  end

  // Storage only; validity is what the reset clears.
  always_ff @(posedge clock) begin
    if (i_fill)    r_tag[i_index] <= i_tag;
    if (i_data_we) r_data[w_addr] <= i_wdata;
  end

  assign o_tag   = r_tag[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_rdata = r_data[w_addr];

endmodule

// File: rtl/assoc_wb_cache_controller.sv
// Set-associative write-back, write-allocate cache controller with burst refill/write-back.
// Optional CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module assoc_wb_cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned INDEX_BITS     = 5,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned WAYS           = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       o_hit_count,
  output logic [31:0]       o_miss_count,
  output logic [31:0]       o_wb_count
`endif
);

  localparam int unsigned OffW  = byte_off_w(DATA_W);
  localparam int unsigned WordW = word_off_w(WORDS_PER_LINE);
  localparam int unsigned TagW  = tag_w(ADDR_W, DATA_W, INDEX_BITS, WORDS_PER_LINE);
  localparam int unsigned Sets  = 1 << INDEX_BITS;
  localparam logic [WordW-1:0]  LastBeat = WordW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] BeatStep = ADDR_W'(DATA_W / 8);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_write, w_write_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [WordW-1:0]    r_beat, w_beat_nxt;
  logic                r_victim, w_victim_nxt;
  logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_nxt;
  logic                r_cpu_ready, w_cpu_ready_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_read, w_mem_read_nxt;
  logic                r_mem_write, w_mem_write_nxt;

  logic [TagW-1:0]       w_req_tag;
  logic [INDEX_BITS-1:0] w_req_idx;
  logic [WordW-1:0]      w_req_word, w_word_sel;
  logic [MaxAddrW-1:0]   w_base_full;
  logic [ADDR_W-1:0]     w_req_base;
  logic [DATA_W-1:0]     w_way_wdata;

  logic [TagW-1:0]   w_tag   [WAYS];
  logic [DATA_W-1:0] w_rdata [WAYS];
  logic [WAYS-1:0]   w_valid, w_dirty, w_hit, w_we, w_fill, w_set_dirty, w_clr_dirty;
  logic              w_hit_any, w_hit_way, w_victim, w_lru_cur, w_lru_we, w_lru_val;
  logic              w_hit_evt, w_miss_evt, w_wb_evt;
  logic              w_unused;

  assign w_req_tag   = r_addr[ADDR_W-1 -: TagW];
  assign w_req_idx   = r_addr[OffW+WordW +: INDEX_BITS];
  assign w_req_word  = r_addr[OffW +: WordW];
  assign w_base_full = line_base(MaxAddrW'(r_addr), OffW + WordW);
  assign w_req_base  = w_base_full[ADDR_W-1:0];
  assign w_word_sel  = (r_state == StWriteback || r_state == StRefill) ? r_beat : w_req_word;
  assign w_way_wdata = (r_state == StRefill) ? i_mem_rdata : r_wdata;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(
      .DATA_W(DATA_W),
      .IDX_W (INDEX_BITS),
      .WORD_W(WordW),
      .TAG_W (TagW)
    ) u_way (
      .clock      (clock),
      .reset      (reset),
      .i_index    (w_req_idx),
      .i_word     (w_word_sel),
      .i_data_we  (w_we[g]),
      .i_wdata    (w_way_wdata),
      .i_fill     (w_fill[g]),
      .i_tag      (w_req_tag),
      .i_set_dirty(w_set_dirty[g]),
      .i_clr_dirty(w_clr_dirty[g]),
      .o_tag      (w_tag[g]),
      .o_valid    (w_valid[g]),
      .o_dirty    (w_dirty[g]),
      .o_rdata    (w_rdata[g])
    );
    assign w_hit[g] = w_valid[g] && (w_tag[g] == w_req_tag);
  end

  // One LRU bit per set names the way to evict next.
  if (WAYS == 2) begin : g_lru
    logic [Sets-1:0] r_lru;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)         r_lru <= '0;
      else if (w_lru_we) r_lru[w_req_idx] <= w_lru_val;
    end
    assign w_lru_cur = r_lru[w_req_idx];
  end else begin : g_no_lru
    assign w_lru_cur = 1'b0;
  end

  assign w_hit_any = |w_hit;
  assign w_hit_way = (WAYS == 2) ? w_hit[WAYS-1] : 1'b0;
  assign w_victim  = !w_valid[0]                         ? 1'b0 :
                     (WAYS == 2 && !w_valid[WAYS-1])     ? 1'b1 : w_lru_cur;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_write_nxt     = r_write;
    w_wdata_nxt     = r_wdata;
    w_beat_nxt      = r_beat;
    w_victim_nxt    = r_victim;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_cpu_ready_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_we            = '0;
    w_fill          = '0;
    w_set_dirty     = '0;
    w_clr_dirty     = '0;
    w_lru_we        = 1'b0;
    w_lru_val       = 1'b0;
    w_hit_evt       = 1'b0;
    w_miss_evt      = 1'b0;
    w_wb_evt        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_cpu_ready && (i_cpu_read || i_cpu_write)) begin
          w_addr_nxt  = i_cpu_addr;
          w_write_nxt = i_cpu_write;
          w_wdata_nxt = i_cpu_wdata;
          w_state_nxt = StLookup;
        end
      end
      StLookup: begin
        if (w_hit_any) begin
          w_hit_evt       = 1'b1;
          w_cpu_ready_nxt = 1'b1;
          w_lru_we        = 1'b1;
          w_lru_val       = ~w_hit_way;
          if (r_write) begin
            w_we[w_hit_way]        = 1'b1;
            w_set_dirty[w_hit_way] = 1'b1;
          end else begin
            w_cpu_rdata_nxt = w_rdata[w_hit_way];
          end
          w_state_nxt = StIdle;
        end else begin
          w_miss_evt   = 1'b1;
          w_victim_nxt = w_victim;
          w_beat_nxt   = '0;
          if (w_valid[w_victim] && w_dirty[w_victim]) begin
            w_wb_evt        = 1'b1;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = {w_tag[w_victim], w_req_idx, {(WordW + OffW){1'b0}}};
            w_state_nxt     = StWriteback;
          end else begin
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = w_req_base;
            w_state_nxt    = StRefill;
          end
        end
      end
      StWriteback: begin
        if (i_mem_ready) begin
          if (r_beat == LastBeat) begin
            w_mem_write_nxt       = 1'b0;
            w_clr_dirty[r_victim] = 1'b1;
            w_mem_read_nxt        = 1'b1;
            w_mem_addr_nxt        = w_req_base;
            w_beat_nxt            = '0;
            w_state_nxt           = StRefill;
          end else begin
            w_beat_nxt     = r_beat + WordW'(1);
            w_mem_addr_nxt = r_mem_addr + BeatStep;
          end
        end
      end
      StRefill: begin
        if (i_mem_ready) begin
          w_we[r_victim] = 1'b1;
          if (r_beat == LastBeat) begin
            w_mem_read_nxt   = 1'b0;
            w_fill[r_victim] = 1'b1;
            w_beat_nxt       = '0;
            w_state_nxt      = StRespond;
          end else begin
            w_beat_nxt     = r_beat + WordW'(1);
            w_mem_addr_nxt = r_mem_addr + BeatStep;
          end
        end
      end
      StRespond: begin
        w_cpu_ready_nxt = 1'b1;
        w_lru_we        = 1'b1;
        w_lru_val       = ~r_victim;
        if (r_write) begin
          w_we[r_victim]        = 1'b1;
          w_set_dirty[r_victim] = 1'b1;
        end else begin
          w_cpu_rdata_nxt = w_rdata[r_victim];
        end
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_beat      <= '0;
      r_victim    <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_write     <= w_write_nxt;
      r_wdata     <= w_wdata_nxt;
      r_beat      <= w_beat_nxt;
      r_victim    <= w_victim_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  // Write-back data is read straight from the victim way at the current beat.
  assign o_mem_wdata = r_mem_write ? w_rdata[r_victim] : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count, r_wb_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_hit_evt && r_hit_count != '1)   r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss_evt && r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
      if (w_wb_evt && r_wb_count != '1)     r_wb_count   <= r_wb_count + 32'd1;
    end
  end
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_wb_count   = r_wb_count;
`endif

  assign w_unused = ^{r_addr[OffW-1:0], w_base_full, w_lru_we, w_lru_val,
                      w_hit_evt, w_miss_evt, w_wb_evt};

endmodule

// File: tb/tb_assoc_wb_cache_controller.sv
// Directed bench for assoc_wb_cache_controller: transaction table plus stall and reset sequences.
module tb_assoc_wb_cache_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_cpu_addr, i_cpu_wdata, i_mem_rdata;
  logic        i_cpu_read, i_cpu_write, i_mem_ready;
  logic [31:0] o_cpu_rdata, o_mem_addr, o_mem_wdata;
  logic        o_cpu_ready, o_mem_read, o_mem_write;
`ifdef CACHE_STATS_EN
  logic [31:0] o_hit_count, o_miss_count, o_wb_count;
`endif

  assoc_wb_cache_controller dut (
    .clock      (clock),
    .reset      (reset),
    .i_cpu_addr (i_cpu_addr),
    .i_cpu_read (i_cpu_read),
    .i_cpu_write(i_cpu_write),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_ready(o_cpu_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_read (o_mem_read),
    .o_mem_write(o_mem_write),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .o_hit_count (o_hit_count),
    .o_miss_count(o_miss_count),
    .o_wb_count  (o_wb_count)
`endif
  );

  always #5 clock = ~clock;

  // Word memory: initial content of byte address a is 0x90 + a/4 (0x40 -> 0xA0).
  logic [31:0] mem [1024];
  bit          stall = 1'b0;
  int          rd_beats, wr_beats;
  logic [31:0] first_rd, first_wr;
  logic [31:0] wr_data_log [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Beats are presented at the falling edge and taken by the DUT at the next rising edge.
  always @(negedge clock) begin
    if ((o_mem_read || o_mem_write) && !stall && !reset) begin
      i_mem_ready = 1'b1;
      if (o_mem_read) begin
        if (rd_beats == 0) first_rd = o_mem_addr;
        rd_beats++;
        i_mem_rdata = mem[o_mem_addr[11:2]];
      end else begin
        if (wr_beats == 0) first_wr = o_mem_addr;
        if (wr_beats < 8) wr_data_log[wr_beats] = o_mem_wdata;
        wr_beats++;
        mem[o_mem_addr[11:2]] = o_mem_wdata;
        i_mem_rdata = '0;
      end
    end else begin
      i_mem_ready = 1'b0;
      i_mem_rdata = '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    @(negedge clock);
    rd_beats = 0;
    wr_beats = 0;
    i_cpu_addr  = addr;
    i_cpu_wdata = wdata;
    i_cpu_write = wr;
    i_cpu_read  = !wr;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!o_cpu_ready && lat < 200);
    check("cpu_ready_seen", {31'd0, o_cpu_ready}, 32'd1);
    rdata = o_cpu_rdata;
    i_cpu_read  = 1'b0;
    i_cpu_write = 1'b0;
    @(negedge clock);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_rd_base;
    logic [31:0] exp_wr_base;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] exp_wb [4];
  logic [31:0] rdata;
  int          lat, guard;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Set 4 is 0x40/0x240/0x440/0x640/0x840; set 8 is 0x80.
    vecs[0]  = '{0, 32'h040, 32'h0,    32'h0A0,  7, 4, 0, 32'h040, 32'h0};
    vecs[1]  = '{0, 32'h044, 32'h0,    32'h0A1,  2, 0, 0, 32'h0,   32'h0};
    vecs[2]  = '{1, 32'h044, 32'h1234, 32'h0,    2, 0, 0, 32'h0,   32'h0};
    vecs[3]  = '{0, 32'h240, 32'h0,    32'h120,  7, 4, 0, 32'h240, 32'h0};
    vecs[4]  = '{0, 32'h440, 32'h0,    32'h1A0, 11, 4, 4, 32'h440, 32'h040};
    vecs[5]  = '{0, 32'h044, 32'h0,    32'h1234, 7, 4, 0, 32'h040, 32'h0};
    vecs[6]  = '{1, 32'h080, 32'hBEEF, 32'h0,    7, 4, 0, 32'h080, 32'h0};
    vecs[7]  = '{0, 32'h080, 32'h0,    32'hBEEF, 2, 0, 0, 32'h0,   32'h0};
    vecs[8]  = '{0, 32'h084, 32'h0,    32'h0B1,  2, 0, 0, 32'h0,   32'h0};
    vecs[9]  = '{0, 32'h448, 32'h0,    32'h1A2,  2, 0, 0, 32'h0,   32'h0};
    vecs[10] = '{1, 32'h04C, 32'h55,   32'h0,    2, 0, 0, 32'h0,   32'h0};
    vecs[11] = '{0, 32'h04C, 32'h0,    32'h55,   2, 0, 0, 32'h0,   32'h0};
    exp_wb   = '{32'h0A0, 32'h1234, 32'h0A2, 32'h0A3};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h90 + i;
    reset       = 1'b1;
    i_cpu_addr  = '0;
    i_cpu_wdata = '0;
    i_cpu_read  = 1'b0;
    i_cpu_write = 1'b0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    #1;
    check("reset_cpu_ready", {31'd0, o_cpu_ready}, 32'd0);
    check("reset_cpu_rdata", o_cpu_rdata, 32'd0);
    check("reset_mem_read",  {31'd0, o_mem_read}, 32'd0);
    check("reset_mem_write", {31'd0, o_mem_write}, 32'd0);
    check("reset_mem_addr",  o_mem_addr, 32'd0);
    check("reset_mem_wdata", o_mem_wdata, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, lat);
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rd_beats", i), rd_beats, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_beats", i), wr_beats, vecs[i].exp_wr);
      if (vecs[i].exp_rd > 0) check($sformatf("v%0d_rd_base", i), first_rd, vecs[i].exp_rd_base);
      if (vecs[i].exp_wr > 0) check($sformatf("v%0d_wr_base", i), first_wr, vecs[i].exp_wr_base);
      if (vecs[i].exp_wr == 4)
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d_wb_beat%0d", i, k), wr_data_log[k], exp_wb[k]);
    end

    // Refill of 0x640 stalled after two beats: address must hold at 0x648.
    @(negedge clock);
    rd_beats = 0;
    wr_beats = 0;
    i_cpu_addr = 32'h640;
    i_cpu_read = 1'b1;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (rd_beats < 2 && guard < 100);
    check("stall_two_beats", rd_beats, 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("stall%0d_addr", k), o_mem_addr, 32'h648);
      check($sformatf("stall%0d_ready", k), {31'd0, o_cpu_ready}, 32'd0);
    end
    check("stall_beats_held", rd_beats, 32'd2);
    stall = 1'b0;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (!o_cpu_ready && guard < 100);
    check("stall_done_ready", {31'd0, o_cpu_ready}, 32'd1);
    check("stall_rdata", o_cpu_rdata, 32'h220);
    check("stall_rd_beats", rd_beats, 32'd4);
    i_cpu_read = 1'b0;
    @(negedge clock);

    // Read 0x840 evicts the dirty 0x40 line; reset lands during write-back beat 2.
    @(negedge clock);
    rd_beats = 0;
    wr_beats = 0;
    i_cpu_addr = 32'h840;
    i_cpu_read = 1'b1;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (wr_beats < 2 && guard < 100);
    check("wb_beat2_addr", o_mem_addr, 32'h048);
    check("wb_beat2_write", {31'd0, o_mem_write}, 32'd1);
    check("wb_beat2_wdata", o_mem_wdata, 32'h0A2);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mem_write", {31'd0, o_mem_write}, 32'd0);
    check("rst_mem_read",  {31'd0, o_mem_read}, 32'd0);
    i_cpu_read = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Every line is invalid now; the unwritten 0x55 and 0xBEEF are gone.
    do_req(1'b0, 32'h04C, 32'h0, rdata, lat);
    check("post_rst_4c_rdata", rdata, 32'h0A3);
    check("post_rst_4c_lat", lat, 32'd7);
    check("post_rst_4c_wr", wr_beats, 32'd0);
    do_req(1'b0, 32'h080, 32'h0, rdata, lat);
    check("post_rst_80_rdata", rdata, 32'h0B0);
    check("post_rst_80_lat", lat, 32'd7);
    check("post_rst_80_wr", wr_beats, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
